// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU sharing arbiter: requester count and the
// ALU control codes understood by the downstream ALU.
package alu_share_arbiter_pkg;

    localparam int unsigned NUM_REQ    = 2;
    localparam int unsigned ALU_CTRL_W = 6;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 6'b000000;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 6'b000010;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = 6'b000011;
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 6'b000100;
    localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 6'b000111;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 6'b001000;
    localparam logic [ALU_CTRL_W-1:0] ALU_BEQ  = 6'b010000;
    localparam logic [ALU_CTRL_W-1:0] ALU_BNE  = 6'b010001;
    localparam logic [ALU_CTRL_W-1:0] ALU_BLT  = 6'b010100;
    localparam logic [ALU_CTRL_W-1:0] ALU_JAL  = 6'b011111;

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter (purely combinational).
//   eligible   : per-requester request qualified by downstream space
//   last_grant : index of the requester granted most recently
//   grant      : one-hot grant, zero when nobody is eligible
module rr_arbiter2
    import alu_share_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] eligible,
    input  logic               last_grant,
    output logic [NUM_REQ-1:0] grant
);

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant = '0;
        unique case (eligible)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between the execute stage (port 0) and the
// address/branch-target helper (port 1). One operation is granted per cycle,
// the ALU output is captured into the requester's response register and is
// presented one cycle later on a valid/ready response channel.
//   clock, reset              : rising-edge clock, async active-high reset
//   req_*                     : per-requester operation channel (valid/ready)
//   rsp_*                     : per-requester response channel (valid/ready)
//   alu_ctrl .. alu_operand_b : drive to the shared ALU (zero when idle)
//   alu_result, alu_branch    : returned from the shared ALU
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CTRL_WIDTH = 6,
    parameter int unsigned RR_INIT    = 0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*CTRL_WIDTH-1:0] req_ctrl,
    input  logic [NUM_REQ-1:0]            req_branch_op,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op_b,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [NUM_REQ*DATA_WIDTH-1:0] rsp_result,
    output logic [NUM_REQ-1:0]            rsp_branch,
    output logic [CTRL_WIDTH-1:0]         alu_ctrl,
    output logic                          alu_branch_op,
    output logic [DATA_WIDTH-1:0]         alu_operand_a,
    output logic [DATA_WIDTH-1:0]         alu_operand_b,
    input  logic [DATA_WIDTH-1:0]         alu_result,
    input  logic                          alu_branch
);

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic               last_grant;

    // A slot being drained this cycle counts as free; nothing is granted in reset.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            eligible[i] = req_valid[i] && (!rsp_valid[i] || rsp_ready[i]) && !reset;
        end
    end

    rr_arbiter2 u_rr_arbiter2 (
        .eligible   (eligible),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign req_ready = grant;

    // Steer the granted requester's fields to the ALU; drive zeros when idle.
    always_comb begin
        alu_ctrl      = '0;
        alu_branch_op = 1'b0;
        alu_operand_a = '0;
        alu_operand_b = '0;
        if (grant[1]) begin
            alu_ctrl      = req_ctrl[2*CTRL_WIDTH-1:CTRL_WIDTH];
            alu_branch_op = req_branch_op[1];
            alu_operand_a = req_op_a[2*DATA_WIDTH-1:DATA_WIDTH];
            alu_operand_b = req_op_b[2*DATA_WIDTH-1:DATA_WIDTH];
        end else if (grant[0]) begin
            alu_ctrl      = req_ctrl[CTRL_WIDTH-1:0];
            alu_branch_op = req_branch_op[0];
            alu_operand_a = req_op_a[DATA_WIDTH-1:0];
            alu_operand_b = req_op_b[DATA_WIDTH-1:0];
        end
    end

    // Per-requester response registers plus round-robin history.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsp_valid  <= '0;
            rsp_result <= '0;
            rsp_branch <= '0;
            last_grant <= 1'(RR_INIT);
        end else begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (grant[i]) begin
                    rsp_result[i*DATA_WIDTH +: DATA_WIDTH] <= alu_result;
                    rsp_branch[i]                          <= alu_branch;
                    rsp_valid[i]                           <= 1'b1;
                end else if (rsp_ready[i]) begin
                    rsp_valid[i] <= 1'b0;
                end
            end
            if (grant != '0) begin
                last_grant <= grant[1];
            end
        end
    end

endmodule
